// File: rtl/base_aforce_cnt.sv
// Multi-channel counted force cell: each channel passes valid/ready through until a
// load request makes it emit exactly N manufactured beats while holding upstream.
module base_aforce_cnt #(
    parameter int width  = 1,
    parameter int cwidth = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [0:width-1]        req_v,
    input  logic [0:width*cwidth-1] req_cnt,
    output logic [0:width-1]        req_r,
    input  logic [0:width-1]        i_v,
    output logic [0:width-1]        i_r,
    output logic [0:width-1]        o_v,
    input  logic [0:width-1]        o_r,
    output logic [0:width-1]        o_forced,
    output logic [0:width-1]        busy,
    output logic [0:width-1]        done
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FORCE = 1'b1;

    for (genvar c = 0; c < width; c++) begin : g_ch
        logic [0:0]        state_q, state_d;
        logic [cwidth-1:0] cnt_q, cnt_d;
        logic              done_q, done_d;
        logic [cwidth-1:0] ld_cnt;
        logic              in_force;
        logic              ld_fire;

        // Field is stored MSB-first at the low index; the part-select keeps that order.
        assign ld_cnt   = req_cnt[c*cwidth +: cwidth];
        assign in_force = (state_q == ST_FORCE);
        assign ld_fire  = req_v[c] & req_r[c];

        assign req_r[c]    = ~in_force & ~reset;
        assign o_v[c]      = in_force ? 1'b1 : i_v[c];
        assign i_r[c]      = in_force ? 1'b0 : o_r[c];
        assign o_forced[c] = in_force;
        assign busy[c]     = in_force;
        assign done[c]     = done_q;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            done_d  = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (ld_fire) begin
                        if (ld_cnt != '0) begin
                            state_d = ST_FORCE;
                            cnt_d   = ld_cnt;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                default: begin
                    if (o_r[c]) begin
                        // Last beat (or an impossible empty count) leaves FORCE; never wrap.
                        if (cnt_q > cwidth'(1)) begin
                            cnt_d = cnt_q - cwidth'(1);
                        end else begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                            done_d  = (cnt_q != '0);
                        end
                    end
                end
            endcase
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                done_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                done_q  <= done_d;
            end
        end
    end

endmodule

// File: tb/tb_base_aforce_cnt.sv
// Directed bench for base_aforce_cnt (4 channels, 8-bit counts) with a
// queue-based scoreboard checked by an independent negedge monitor.
module tb_base_aforce_cnt;

    localparam int W  = 4;
    localparam int CW = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [0:W-1]    req_v = '0;
    logic [0:W*CW-1] req_cnt = '0;
    logic [0:W-1]    req_r;
    logic [0:W-1]    i_v = '0;
    logic [0:W-1]    i_r;
    logic [0:W-1]    o_v;
    logic [0:W-1]    o_r = '0;
    logic [0:W-1]    o_forced;
    logic [0:W-1]    busy;
    logic [0:W-1]    done;

    base_aforce_cnt #(.width(W), .cwidth(CW)) dut (
        .clk(clk), .reset(reset),
        .req_v(req_v), .req_cnt(req_cnt), .req_r(req_r),
        .i_v(i_v), .i_r(i_r),
        .o_v(o_v), .o_r(o_r),
        .o_forced(o_forced), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] exp;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Expected vector layout: {o_v, i_r, o_forced, busy, done, req_r}, ch0 leftmost.
    function automatic logic [23:0] e(input logic [3:0] ov, input logic [3:0] ir,
                                      input logic [3:0] f, input logic [3:0] b,
                                      input logic [3:0] d, input logic [3:0] rr);
        return {ov, ir, f, b, d, rr};
    endfunction

    task automatic step(input logic [3:0] rv, input logic [31:0] rc, input logic [3:0] iv,
                        input logic [3:0] orr, input logic rst_v, input logic [23:0] ex,
                        input string nm);
        exp_t it;
        req_v   = rv;
        req_cnt = rc;
        i_v     = iv;
        o_r     = orr;
        reset   = rst_v;
        it.exp  = ex;
        it.nm   = nm;
        sb.push_back(it);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t        it;
            logic [23:0] act;
            it  = sb.pop_front();
            act = {o_v, i_r, o_forced, busy, done, req_r};
            n_cmp++;
            if (act !== it.exp)
                begin
                    n_err++;
                    $display("FAIL %s: got ov/ir/f/b/d/rr=%b_%b_%b_%b_%b_%b required %b_%b_%b_%b_%b_%b",
                             it.nm, act[23:20], act[19:16], act[15:12], act[11:8], act[7:4], act[3:0],
                             it.exp[23:20], it.exp[19:16], it.exp[15:12], it.exp[11:8],
                             it.exp[7:4], it.exp[3:0]);
                end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time budget");
        $fatal(1, "timeout");
    end

    initial begin
        @(posedge clk);
        #1;
        // Reset state: pass-through but req_r low
        step(4'b0000, 32'd0, 4'b1010, 4'b0110, 1'b1, e(4'b1010, 4'b0110, 0, 0, 0, 4'b0000), "reset_state");
        // Pass-through
        step(4'b0000, 32'd0, 4'b1010, 4'b0110, 1'b0, e(4'b1010, 4'b0110, 0, 0, 0, 4'b1111), "pass_a");
        step(4'b0000, 32'd0, 4'b0101, 4'b1001, 1'b0, e(4'b0101, 4'b1001, 0, 0, 0, 4'b1111), "pass_b");

        // Load ch0 count 3, o_r high, ch0 upstream valid held
        step(4'b1000, {8'd3, 24'd0}, 4'b1000, 4'b1111, 1'b0, e(4'b1000, 4'b1111, 0, 0, 0, 4'b1111), "ld3_accept");
        for (int i = 0; i < 3; i++)
            step(4'b0000, 32'd0, 4'b1000, 4'b1111, 1'b0, e(4'b1000, 4'b0111, 4'b1000, 4'b1000, 0, 4'b0111), "ld3_force");
        step(4'b0000, 32'd0, 4'b1000, 4'b1111, 1'b0, e(4'b1000, 4'b1111, 0, 0, 4'b1000, 4'b1111), "ld3_done");
        step(4'b0000, 32'd0, 4'b1000, 4'b1111, 1'b0, e(4'b1000, 4'b1111, 0, 0, 0, 4'b1111), "ld3_after");

        // Stall mid-burst, count 2, o_r 1,0,0,1
        step(4'b1000, {8'd2, 24'd0}, 4'b0000, 4'b0000, 1'b0, e(0, 0, 0, 0, 0, 4'b1111), "stall_accept");
        step(4'b0000, 32'd0, 4'b0000, 4'b1000, 1'b0, e(4'b1000, 0, 4'b1000, 4'b1000, 0, 4'b0111), "stall_c1");
        step(4'b0000, 32'd0, 4'b0000, 4'b0000, 1'b0, e(4'b1000, 0, 4'b1000, 4'b1000, 0, 4'b0111), "stall_c2");
        step(4'b0000, 32'd0, 4'b0000, 4'b0000, 1'b0, e(4'b1000, 0, 4'b1000, 4'b1000, 0, 4'b0111), "stall_c3");
        step(4'b0000, 32'd0, 4'b0000, 4'b1000, 1'b0, e(4'b1000, 0, 4'b1000, 4'b1000, 0, 4'b0111), "stall_c4");
        step(4'b0000, 32'd0, 4'b0000, 4'b0000, 1'b0, e(0, 0, 0, 0, 4'b1000, 4'b1111), "stall_done");
        step(4'b0000, 32'd0, 4'b0000, 4'b1000, 1'b0, e(0, 4'b1000, 0, 0, 0, 4'b1111), "stall_after");

        // Zero count: no-op with done next cycle
        step(4'b1000, 32'd0, 4'b0000, 4'b0000, 1'b0, e(0, 0, 0, 0, 0, 4'b1111), "zero_accept");
        step(4'b0000, 32'd0, 4'b0000, 4'b0000, 1'b0, e(0, 0, 0, 0, 4'b1000, 4'b1111), "zero_done");
        step(4'b0000, 32'd0, 4'b0000, 4'b0000, 1'b0, e(0, 0, 0, 0, 0, 4'b1111), "zero_after");

        // Maximum count 255 on ch1
        step(4'b0100, {8'd0, 8'd255, 16'd0}, 4'b0000, 4'b1111, 1'b0, e(0, 4'b1111, 0, 0, 0, 4'b1111), "max_accept");
        for (int i = 0; i < 255; i++)
            step(4'b0000, 32'd0, 4'b0000, 4'b1111, 1'b0, e(4'b0100, 4'b1011, 4'b0100, 4'b0100, 0, 4'b1011), "max_force");
        step(4'b0000, 32'd0, 4'b0000, 4'b1111, 1'b0, e(0, 4'b1111, 0, 0, 4'b0100, 4'b1111), "max_done");

        // Independence, then asynchronous reset after 2 of ch0's 5 beats
        step(4'b1000, {8'd5, 24'd0}, 4'b0000, 4'b1111, 1'b0, e(0, 4'b1111, 0, 0, 0, 4'b1111), "ind_accept");
        step(4'b0000, 32'd0, 4'b0100, 4'b1111, 1'b0, e(4'b1100, 4'b0111, 4'b1000, 4'b1000, 0, 4'b0111), "ind_b1");
        step(4'b0000, 32'd0, 4'b0100, 4'b1111, 1'b0, e(4'b1100, 4'b0111, 4'b1000, 4'b1000, 0, 4'b0111), "ind_b2");
        step(4'b0000, 32'd0, 4'b0100, 4'b1111, 1'b1, e(4'b0100, 4'b1111, 0, 0, 0, 4'b0000), "ind_reset");
        step(4'b0000, 32'd0, 4'b0000, 4'b1111, 1'b0, e(0, 4'b1111, 0, 0, 0, 4'b1111), "ind_no_done");
        step(4'b1000, {8'd1, 24'd0}, 4'b0000, 4'b1111, 1'b0, e(0, 4'b1111, 0, 0, 0, 4'b1111), "fresh1_accept");
        step(4'b0000, 32'd0, 4'b0000, 4'b1111, 1'b0, e(4'b1000, 4'b0111, 4'b1000, 4'b1000, 0, 4'b0111), "fresh1_force");
        step(4'b0000, 32'd0, 4'b0000, 4'b1111, 1'b0, e(0, 4'b1111, 0, 0, 4'b1000, 4'b1111), "fresh1_done");
        step(4'b0000, 32'd0, 4'b0000, 4'b1111, 1'b0, e(0, 4'b1111, 0, 0, 0, 4'b1111), "fresh1_after");

        // Back-to-back with req_v held high, count 2
        step(4'b1000, {8'd2, 24'd0}, 4'b0000, 4'b1111, 1'b0, e(0, 4'b1111, 0, 0, 0, 4'b1111), "b2b_accept1");
        step(4'b1000, {8'd2, 24'd0}, 4'b0000, 4'b1111, 1'b0, e(4'b1000, 4'b0111, 4'b1000, 4'b1000, 0, 4'b0111), "b2b_f1a");
        step(4'b1000, {8'd2, 24'd0}, 4'b0000, 4'b1111, 1'b0, e(4'b1000, 4'b0111, 4'b1000, 4'b1000, 0, 4'b0111), "b2b_f1b");
        step(4'b1000, {8'd2, 24'd0}, 4'b0000, 4'b1111, 1'b0, e(0, 4'b1111, 0, 0, 4'b1000, 4'b1111), "b2b_gap");
        step(4'b1000, {8'd2, 24'd0}, 4'b0000, 4'b1111, 1'b0, e(4'b1000, 4'b0111, 4'b1000, 4'b1000, 0, 4'b0111), "b2b_f2a");
        step(4'b1000, {8'd2, 24'd0}, 4'b0000, 4'b1111, 1'b0, e(4'b1000, 4'b0111, 4'b1000, 4'b1000, 0, 4'b0111), "b2b_f2b");
        step(4'b0000, 32'd0, 4'b0000, 4'b1111, 1'b0, e(0, 4'b1111, 0, 0, 4'b1000, 4'b1111), "b2b_done2");
        step(4'b0000, 32'd0, 4'b0000, 4'b1111, 1'b0, e(0, 4'b1111, 0, 0, 0, 4'b1111), "b2b_idle");

        @(posedge clk);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d pending entries required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
